// File: rtl/muldiv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : muldiv_pkg                                                  |
// | Purpose  : Shared definitions for the EX-stage multiply/divide unit:   |
// |            operation encodings, FSM state encoding and default width.  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter_core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : muldiv_iter_core                                            |
// | Purpose  : One shift-add (multiply) or restoring-subtract (divide)     |
// |            step per cycle on unsigned magnitudes.                      |
// |            Multiply: {hi,lo} ends as the 2*WIDTH product.              |
// |            Divide  : lo ends as quotient, hi as remainder.             |
// | Config   : MULDIV_DIV_EN builds the divide step; otherwise only the    |
// |            multiplier datapath exists.                                 |
// | Ports    : clk, rst         clock / sync active-high reset             |
// |            load             capture operands (a_mag, b_mag, is_div)    |
// |            step             perform one iteration                      |
// |            hi, lo           shift-register halves                      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor
  logic [WIDTH:0]   mul_sum;

  // Add the multiplicand when the current multiplier LSB is set; the carry
  // becomes the new top bit after the right shift.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

`ifdef MULDIV_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             fits;

  // Remainder shifted left by one, pulling in the next dividend bit.
  assign rem_sh   = {hi_q, lo_q[WIDTH-1]};
  assign fits     = (rem_sh >= {1'b0, opnd_q});
  // When the divisor fits the difference is below 2^WIDTH, so WIDTH bits suffice.
  assign rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
`endif

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
`ifdef MULDIV_DIV_EN
    div_d  = div_q;
`endif
    if (load) begin
      hi_d   = '0;
`ifdef MULDIV_DIV_EN
      div_d  = is_div;
      lo_d   = is_div ? a_mag : b_mag;
      opnd_d = is_div ? b_mag : a_mag;
`else
      lo_d   = b_mag;
      opnd_d = a_mag;
`endif
    end else if (step) begin
`ifdef MULDIV_DIV_EN
      if (div_q) begin
        hi_d = fits ? rem_diff : rem_sh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], fits};
      end else
`endif
      begin
        {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
`ifdef MULDIV_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
`ifdef MULDIV_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ex_muldiv_unit                                              |
// | Purpose  : Iterative MULT/MULTU/DIV/DIVU engine in EX. Owns HI/LO,     |
// |            serves MTHI/MTLO, and requests a stall while busy.          |
// | Config   : MULDIV_DIV_EN enables DIV/DIVU; without it ops 10/11 are    |
// |            ignored and no divider is built.                            |
// | Ports    : CLK, RESET              clock / sync active-high reset      |
// |            I_MD_Start/Op/A/B       operation issue from ID/EX          |
// |            I_MD_HiWr/LoWr/WData    MTHI / MTLO                         |
// |            I_MD_HiLoRd             MFHI/MFLO pending in ID             |
// |            I_MD_Flush              abort in-flight op                  |
// |            O_MD_HI/LO              architectural HI/LO                 |
// |            O_MD_Busy/Done/Stall    status and hazard request           |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_MD_Start,
  input  logic [1:0]       I_MD_Op,
  input  logic [WIDTH-1:0] I_MD_A,
  input  logic [WIDTH-1:0] I_MD_B,
  input  logic             I_MD_HiWr,
  input  logic             I_MD_LoWr,
  input  logic [WIDTH-1:0] I_MD_WData,
  input  logic             I_MD_HiLoRd,
  input  logic             I_MD_Flush,
  output logic [WIDTH-1:0] O_MD_HI,
  output logic [WIDTH-1:0] O_MD_LO,
  output logic             O_MD_Busy,
  output logic             O_MD_Done,
  output logic             O_MD_Stall
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;   // product/quotient sign
  logic               neg_rem_q, neg_rem_d;   // remainder follows dividend
  logic               b_zero_q, b_zero_d;

  logic               op_ok, accept, is_div_op, signed_op, a_neg, b_neg;
  logic               core_step;
  logic [WIDTH-1:0]   a_mag, b_mag, core_hi, core_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MULDIV_DIV_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~I_MD_Op[1];
`endif

  assign O_MD_Busy  = (state_q == RUN) || (state_q == FIX);
  assign O_MD_Done  = done_q;
  assign O_MD_HI    = hi_q;
  assign O_MD_LO    = lo_q;
  assign O_MD_Stall = O_MD_Busy & (I_MD_HiLoRd | I_MD_Start | I_MD_HiWr | I_MD_LoWr);

  // Flush in IDLE/DONE has no state effect but still suppresses a Start.
  assign accept    = I_MD_Start & ~O_MD_Busy & ~I_MD_Flush & op_ok;
  assign is_div_op = I_MD_Op[1];
  assign signed_op = ~I_MD_Op[0];
  assign a_neg     = signed_op & I_MD_A[WIDTH-1];
  assign b_neg     = signed_op & I_MD_B[WIDTH-1];
  assign a_mag     = a_neg ? -I_MD_A : I_MD_A;
  assign b_mag     = b_neg ? -I_MD_B : I_MD_B;
  assign core_step = (state_q == RUN);

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (CLK),
    .rst    (RESET),
    .load   (accept),
    .step   (core_step),
    .is_div (is_div_op),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  // Sign fix-up applied in FIX. A zero divisor leaves |A| as remainder, so
  // re-applying the dividend sign restores A; the quotient is forced to ones.
  assign prod     = {core_hi, core_lo};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo_fix  = b_zero_q ? '1 : (neg_res_q ? -core_lo : core_lo);
  assign rem_fix  = neg_rem_q ? -core_hi : core_hi;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d   = RUN;
          cnt_d     = '0;
          is_div_d  = is_div_op;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          b_zero_d  = (I_MD_B == '0);
        end else begin
          if (I_MD_HiWr) hi_d = I_MD_WData;
          if (I_MD_LoWr) lo_d = I_MD_WData;
        end
      end
      RUN: begin
        if (I_MD_Flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!I_MD_Flush) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_ex_muldiv_unit                                           |
// | Purpose  : Self-checking bench for ex_muldiv_unit: directed cases,     |
// |            flush/reset aborts and randomized ops against an            |
// |            arithmetic reference model.                                 |
// | Config   : honours MULDIV_DIV_EN (divide results vs. ignored divide).  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         CLK;
  logic         RESET;
  logic         I_MD_Start;
  logic [1:0]   I_MD_Op;
  logic [W-1:0] I_MD_A, I_MD_B, I_MD_WData;
  logic         I_MD_HiWr, I_MD_LoWr, I_MD_HiLoRd, I_MD_Flush;
  logic [W-1:0] O_MD_HI, O_MD_LO;
  logic         O_MD_Busy, O_MD_Done, O_MD_Stall;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_hi, exp_lo;

  ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .I_MD_Start  (I_MD_Start),
    .I_MD_Op     (I_MD_Op),
    .I_MD_A      (I_MD_A),
    .I_MD_B      (I_MD_B),
    .I_MD_HiWr   (I_MD_HiWr),
    .I_MD_LoWr   (I_MD_LoWr),
    .I_MD_WData  (I_MD_WData),
    .I_MD_HiLoRd (I_MD_HiLoRd),
    .I_MD_Flush  (I_MD_Flush),
    .O_MD_HI     (O_MD_HI),
    .O_MD_LO     (O_MD_LO),
    .O_MD_Busy   (O_MD_Busy),
    .O_MD_Done   (O_MD_Done),
    .O_MD_Stall  (O_MD_Stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    I_MD_Start  = 1'b0;
    I_MD_HiWr   = 1'b0;
    I_MD_LoWr   = 1'b0;
    I_MD_HiLoRd = 1'b0;
    I_MD_Flush  = 1'b0;
  endtask

  // Reference: plain arithmetic on the architectural operands.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint       sp;
    logic [63:0]  up;
    int           sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin sp = longint'(sa) * longint'(sb); {hi, lo} = sp; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; end
      2'b10: begin
        if (b == 0) begin hi = a; lo = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 0; lo = a; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      default: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [W-1:0] d);
    I_MD_HiWr = hw; I_MD_LoWr = lw; I_MD_WData = d;
    tick();
    I_MD_HiWr = 1'b0; I_MD_LoWr = 1'b0;
    if (hw) exp_hi = d;
    if (lw) exp_lo = d;
    check_eq("mt_hi", O_MD_HI, exp_hi);
    check_eq("mt_lo", O_MD_LO, exp_lo);
  endtask

  // Issues one op and follows it to Done; returns in the Done cycle.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] rh, rl;
    int lat;
    bit seen, rd, st, wr;
    model(op, a, b, rh, rl);
    I_MD_Op = op; I_MD_A = a; I_MD_B = b; I_MD_Start = 1'b1;
    tick();
    I_MD_Start = 1'b0; I_MD_A = $urandom; I_MD_B = $urandom;
`ifndef MULDIV_DIV_EN
    if (op[1]) begin
      check_eq("div_ign_busy", O_MD_Busy, 0);
      check_eq("div_ign_done", O_MD_Done, 0);
      check_eq("div_ign_hi", O_MD_HI, exp_hi);
      check_eq("div_ign_lo", O_MD_LO, exp_lo);
      return;
    end
`endif
    lat = 0;
    seen = 1'b0;
    for (int i = 1; i <= W + 3 && !seen; i++) begin
      rd = 1'($urandom);
      st = (i == 3);
      wr = (i == 5);
      I_MD_HiLoRd = rd;
      if (st) begin I_MD_Start = 1'b1; I_MD_Op = 2'($urandom); end
      if (wr) begin I_MD_HiWr = 1'b1; I_MD_LoWr = 1'b1; I_MD_WData = $urandom; end
      #1;
      check_eq("stall", O_MD_Stall, rd | st | wr);
      check_eq("busy", O_MD_Busy, 1);
      check_eq("hold_hi", O_MD_HI, exp_hi);
      check_eq("hold_lo", O_MD_LO, exp_lo);
      tick();
      clear_in();
      if (O_MD_Done) begin seen = 1'b1; lat = i; end
    end
    check_eq("latency", lat, W + 1);
    exp_hi = rh;
    exp_lo = rl;
    check_eq("res_hi", O_MD_HI, exp_hi);
    check_eq("res_lo", O_MD_LO, exp_lo);
    check_eq("busy_after", O_MD_Busy, 0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] sp [4];
    sp = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
    case ($urandom % 4)
      0, 1:    return $urandom;
      2:       return ($urandom % 2) ? W'($urandom_range(0, 20)) : -W'($urandom_range(1, 20));
      default: return sp[$urandom % 4];
    endcase
  endfunction

  initial begin
    bit seen;
    RESET = 1'b1;
    clear_in();
    I_MD_Op = OP_MULT; I_MD_A = '0; I_MD_B = '0; I_MD_WData = '0;
    exp_hi = '0; exp_lo = '0;
    // Reset must win over a concurrent Start and MTHI.
    I_MD_Start = 1'b1; I_MD_HiWr = 1'b1; I_MD_WData = 32'hFFFF_FFFF;
    tick(); tick();
    check_eq("rst_hi", O_MD_HI, 0);
    check_eq("rst_lo", O_MD_LO, 0);
    check_eq("rst_busy", O_MD_Busy, 0);
    check_eq("rst_done", O_MD_Done, 0);
    clear_in();
    RESET = 1'b0;
    tick();

    run_op(OP_MULT, -32'sd3, 32'd7);
    check_eq("mult_spec_hi", O_MD_HI, 32'hFFFF_FFFF);
    check_eq("mult_spec_lo", O_MD_LO, 32'hFFFF_FFEB);
    check_eq("done_pulse", O_MD_Done, 1);
    tick();
    check_eq("done_one_cycle", O_MD_Done, 0);
    I_MD_HiLoRd = 1'b1;
    #1;
    check_eq("idle_no_stall", O_MD_Stall, 0);
    I_MD_HiLoRd = 1'b0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_eq("multu_spec_hi", O_MD_HI, 32'hFFFF_FFFE);
`ifdef MULDIV_DIV_EN
    run_op(OP_DIV, -32'sd7, 32'd2);
    check_eq("div_spec_lo", O_MD_LO, 32'hFFFF_FFFD);
    run_op(OP_DIVU, 32'd5, 32'd0);
    check_eq("divu0_spec_hi", O_MD_HI, 32'd5);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("divovf_spec_lo", O_MD_LO, 32'h8000_0000);
`else
    tick();
    run_op(OP_DIV, -32'sd7, 32'd2);
    run_op(OP_DIVU, 32'd5, 32'd0);
`endif
    tick();

    mt(1'b1, 1'b0, 32'h1234_5678);
    mt(1'b0, 1'b1, 32'hCAFE_F00D);

    // Start together with Flush in IDLE is ignored.
    I_MD_Op = OP_MULT; I_MD_A = 32'd3; I_MD_B = 32'd3;
    I_MD_Start = 1'b1; I_MD_Flush = 1'b1;
    tick();
    clear_in();
    check_eq("flush_start_busy", O_MD_Busy, 0);

    // Flush at cycle 10 of a MULT.
    mt(1'b1, 1'b1, 32'h0BAD_BEEF);
    I_MD_Op = OP_MULT; I_MD_A = 32'd1234; I_MD_B = 32'd5678; I_MD_Start = 1'b1;
    tick();
    I_MD_Start = 1'b0;
    repeat (9) tick();
    I_MD_Flush = 1'b1;
    tick();
    I_MD_Flush = 1'b0;
    check_eq("flush_busy", O_MD_Busy, 0);
    seen = 1'b0;
    repeat (W + 4) begin tick(); if (O_MD_Done) seen = 1'b1; end
    check_eq("flush_no_done", seen, 0);
    check_eq("flush_hi", O_MD_HI, exp_hi);
    check_eq("flush_lo", O_MD_LO, exp_lo);

    // Reset in the middle of an op.
    mt(1'b1, 1'b1, 32'hA5A5_5A5A);
    I_MD_Op = OP_MULTU; I_MD_A = 32'd99; I_MD_B = 32'd77; I_MD_Start = 1'b1;
    tick();
    I_MD_Start = 1'b0;
    repeat (5) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check_eq("rstmid_busy", O_MD_Busy, 0);
    seen = 1'b0;
    repeat (W + 4) begin tick(); if (O_MD_Done) seen = 1'b1; end
    check_eq("rstmid_no_done", seen, 0);
    check_eq("rstmid_hi", O_MD_HI, 0);
    check_eq("rstmid_lo", O_MD_LO, 0);

    // Randomized ops, including back-to-back issue and MTHI/MTLO from DONE.
    repeat (24) begin
      run_op(2'($urandom), pick(), pick());
      case ($urandom % 3)
        0: ;
        1: mt(1'($urandom), 1'($urandom), $urandom);
        default: begin tick(); mt(1'($urandom), 1'($urandom), $urandom); end
      endcase
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
